// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
// Latency: n/a (types only).
// Backpressure: n/a.
package icache_pkg;

    localparam int SETS_DEF  = 16;
    localparam int IIDX_W    = $clog2(SETS_DEF);
    localparam int ITAG_W    = 30 - IIDX_W;
    // Frame tag field is sized for the smallest legal geometry (2 sets) so one
    // struct serves every SETS value; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 29;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          data;
    } icache_frame_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: iwait from memory stalls the fill; the fetch side sees ihit=0.
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    // master: datapath plus memory controller; slave: the cache itself
    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_array.sv
// Frame storage: combinational read, one synchronous write, flush-all of valid bits.
// Latency: read 0 cycles; a write is visible the cycle after its edge.
// Backpressure: none; flush takes priority over a same-cycle write.
module icache_array
    import icache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output icache_frame_t     rd_frame,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [31:0]       wr_data,
    input  logic              flush
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_frame       = '0;
        rd_frame.valid = valid[rd_idx];
        rd_frame.tag   = TAG_MAX_W'(tag_mem[rd_idx]);
        rd_frame.data  = data_mem[rd_idx];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-block instruction cache; ICACHE_STATS_EN adds hit/miss counters.
// Latency: hit 0 cycles; miss = 1 (enter FILL) + iwait cycles + 1 (write) + 1 (hit).
// Backpressure: iwait holds FILL with iREN/iaddr stable; ihit stays 0 meanwhile.
module icache
    import icache_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    icache_if.slave     ifc
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t  state, state_n;
    logic [29:0]    fill_addr, fill_addr_n;
    icache_frame_t  frame;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic           hit;
    logic           wr_en;

    assign req_tag = ifc.imemaddr[31:IDX_W+2];
    assign req_idx = ifc.imemaddr[IDX_W+1:2];

    // Lookup is only meaningful in IDLE; FILL never reports a hit.
    assign hit = (state == IDLE) && ifc.imemREN && frame.valid
              && (frame.tag == TAG_MAX_W'(req_tag));

    assign wr_en = (state == FILL) && !ifc.iwait && !ifc.iflush;

    icache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (CLK),
        .rst_n    (nRST),
        .rd_idx   (req_idx),
        .rd_frame (frame),
        .wr_en    (wr_en),
        .wr_idx   (fill_addr[IDX_W-1:0]),
        .wr_tag   (fill_addr[29:IDX_W]),
        .wr_data  (ifc.iload),
        .flush    (ifc.iflush)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            fill_addr <= '0;
        end else begin
            state     <= state_n;
            fill_addr <= fill_addr_n;
        end
    end

    always_comb begin
        state_n      = state;
        fill_addr_n  = fill_addr;
        ifc.ihit     = hit;
        ifc.imemload = '0;
        ifc.iREN     = 1'b0;
        ifc.iaddr    = '0;
        if (hit) begin
            ifc.imemload = frame.data;
        end
        case (state)
            IDLE: begin
                if (ifc.imemREN && !hit) begin
                    state_n     = FILL;
                    fill_addr_n = {req_tag, req_idx};
                end
            end
            FILL: begin
                ifc.iREN  = 1'b1;
                ifc.iaddr = {fill_addr, 2'b00};
                // A flush drops the in-flight fill; memory tolerates the abandoned read.
                if (ifc.iflush || !ifc.iwait) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if ((state == IDLE) && (state_n == FILL)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: vector table of fetches plus hand-written flush sequences.
module tb_icache;

    logic CLK;
    logic nRST;

    icache_if ifc ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache #(.SETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ifc        (ifc)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: fixed contents, iwait held high for wait_n cycles of each fill.
    int wait_n;
    int wait_cnt;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        if (a == 32'h0000_0040) return 32'h2001_0005;
        if (a == 32'h0000_0000) return 32'hAAAA_0000;
        return {lo ^ 16'h5A5A, lo};
    endfunction

    always @(posedge CLK) begin
        if (!ifc.iREN) wait_cnt <= 0;
        else if (ifc.iwait) wait_cnt <= wait_cnt + 1;
    end

    assign ifc.iload = mem_val(ifc.iaddr);
    assign ifc.iwait = ifc.iREN && (wait_cnt < wait_n);

    int pass_cnt;
    int total_cnt;
    int exp_hits;
    int exp_misses;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          iren;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [31:0] addr;
        int          wn;
        logic [31:0] data;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Called just after a rising edge; returns just after the edge that follows the hit.
    task automatic fetch(input logic [31:0] a, input int wn, input logic [31:0] ed, input int el);
        sb_t e;
        int  cyc;
        int  iren_cyc;
        bit  addr_ok;
        bit  got;
        logic [31:0] data_seen;
        e.data = ed;
        e.lat  = el;
        e.iren = (el == 0) ? 0 : el - 1;
        sb.push_back(e);
        exp_hits++;
        if (el != 0) exp_misses++;
        wait_n       = wn;
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = a;
        cyc = 0; iren_cyc = 0; addr_ok = 1'b1; got = 1'b0; data_seen = '0;
        while (!got && cyc < 50) begin
            @(negedge CLK);
            if (ifc.ihit) begin
                got       = 1'b1;
                data_seen = ifc.imemload;
            end else begin
                if (ifc.iREN) begin
                    iren_cyc++;
                    if (ifc.iaddr !== {a[31:2], 2'b00}) addr_ok = 1'b0;
                    // Disturb the fetch address while memory stalls; the fill must ignore it.
                    ifc.imemaddr = ifc.iwait ? (a ^ 32'h0000_0100) : a;
                end
                cyc++;
                @(posedge CLK); #1;
            end
        end
        e = sb.pop_front();
        check($sformatf("hit_seen@%08h", a), 32'(got), 32'd1);
        check($sformatf("imemload@%08h", a), data_seen, e.data);
        check($sformatf("latency@%08h", a), 32'(cyc), 32'(e.lat));
        check($sformatf("iren_cycles@%08h", a), 32'(iren_cyc), 32'(e.iren));
        check($sformatf("iaddr_stable@%08h", a), 32'(addr_ok), 32'd1);
        @(posedge CLK); #1;
        ifc.imemREN = 1'b0;
    endtask

    localparam logic [31:0] D40 = 32'h2001_0005;
    localparam logic [31:0] D00 = 32'hAAAA_0000;
    localparam logic [31:0] D04 = 32'h5A5E_0004;
    localparam logic [31:0] D0C = 32'h5A56_000C;
    localparam logic [31:0] D88 = 32'h5AD2_0088;

    vec_t tbl [10];

    initial begin
        bit done;
        int n;

        tbl[0] = '{32'h0000_0040, 0, D40, 2};  // cold miss
        tbl[1] = '{32'h0000_0040, 0, D40, 0};  // repeat hits
        tbl[2] = '{32'h0000_0043, 0, D40, 0};  // offset ignored
        tbl[3] = '{32'h0000_0004, 0, D04, 2};
        tbl[4] = '{32'h0000_0000, 0, D00, 2};  // conflicts with 0x40 in set 0
        tbl[5] = '{32'h0000_0040, 0, D40, 2};
        tbl[6] = '{32'h0000_0000, 0, D00, 2};
        tbl[7] = '{32'h0000_0004, 3, D04, 0};  // other set untouched
        tbl[8] = '{32'h0000_0088, 5, D88, 7};  // slow memory
        tbl[9] = '{32'h0000_0088, 0, D88, 0};

        pass_cnt = 0; total_cnt = 0; exp_hits = 0; exp_misses = 0;
        wait_n = 0;
        nRST = 1'b0;
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = 32'h0000_0040;
        ifc.iflush   = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_ihit", 32'(ifc.ihit), 32'd0);
        check("reset_imemload", ifc.imemload, 32'd0);
        check("reset_iREN", 32'(ifc.iREN), 32'd0);
        check("reset_iaddr", ifc.iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
        check("reset_hit_count", hit_count, 32'd0);
        check("reset_miss_count", miss_count, 32'd0);
`endif
        ifc.imemREN = 1'b0;
        nRST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 10; i++) begin
            fetch(tbl[i].addr, tbl[i].wn, tbl[i].data, tbl[i].lat);
        end

        // Flush lands on the fill-completion cycle: nothing is written, all frames drop.
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = 32'h0000_000C;
        wait_n = 2;
        done = 1'b0;
        n = 0;
        exp_misses++;
        while (!done && n < 50) begin
            @(negedge CLK);
            if (ifc.iREN && !ifc.iwait) begin
                ifc.iflush = 1'b1;
                done = 1'b1;
            end
            n++;
            @(posedge CLK); #1;
        end
        ifc.iflush  = 1'b0;
        ifc.imemREN = 1'b0;
        check("flush_fill_reached", 32'(done), 32'd1);
        @(negedge CLK);
        check("flush_back_to_idle", 32'(ifc.iREN), 32'd0);
        @(posedge CLK); #1;
        fetch(32'h0000_000C, 0, D0C, 2);
        fetch(32'h0000_0004, 0, D04, 2);
        fetch(32'h0000_0088, 0, D88, 2);

        // Flush in IDLE: the same-cycle lookup still sees the old valid bits.
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = 32'h0000_000C;
        ifc.iflush   = 1'b1;
        @(negedge CLK);
        check("flush_idle_hit", 32'(ifc.ihit), 32'd1);
        check("flush_idle_data", ifc.imemload, D0C);
        exp_hits++;
        @(posedge CLK); #1;
        ifc.iflush = 1'b0;
        @(negedge CLK);
        check("post_flush_miss", 32'(ifc.ihit), 32'd0);
        check("post_flush_data", ifc.imemload, 32'd0);
        ifc.imemREN = 1'b0;
        @(posedge CLK); #1;

        // Ten back-to-back hit cycles, then two misses.
        fetch(32'h0000_0088, 0, D88, 2);
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = 32'h0000_0088;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check($sformatf("burst_hit%0d", k), 32'(ifc.ihit), 32'd1);
            exp_hits++;
            @(posedge CLK); #1;
        end
        ifc.imemREN = 1'b0;
        fetch(32'h0000_0040, 0, D40, 2);
        fetch(32'h0000_0000, 0, D00, 2);

        @(negedge CLK);
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
`endif
        check("idle_ihit", 32'(ifc.ihit), 32'd0);
        check("idle_iREN", 32'(ifc.iREN), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
